// File: rtl/mem_responder.sv
// mem_responder: shared-array memory responder for the CPU's fetch port and
// data port. One access is served at a time with a fixed latency; completion
// is signalled by a one-cycle valid pulse on the granted port, and per-port
// stall signals freeze the pipeline while a request is outstanding.
module mem_responder #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // With a one-cycle latency the acceptance edge is also the DONE-entry
    // edge, so the access must use the live request inputs, not the latches.
    localparam bit         SINGLE   = (LATENCY == 1);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam int         DEPTH    = 1 << MEM_AW;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_last_d;     // last grant: 0 = fetch, 1 = data
    logic                r_grant_d;    // port owning the in-flight access
    logic                r_wr;
    logic [MEM_AW-1:0]   r_idx;
    logic [15:0]         r_wdata;
    logic [15:0]         r_if_rdata;
    logic [15:0]         r_d_rdata;
    logic                r_if_valid;
    logic                r_d_valid;

    logic [15:0]         r_mem [0:DEPTH-1];

    logic                w_accept;
    logic                w_grant_d;
    logic                w_enter_done;
    logic [MEM_AW-1:0]   w_acc_idx;
    logic                w_acc_wr;
    logic                w_acc_sel_d;
    logic [15:0]         w_acc_wdata;
    logic [MEM_AW-1:0]   w_req_idx;
    logic                w_unused_addr_bits;

    // Upper address bits alias and bit 0 is a byte offset; neither is decoded.
    assign w_unused_addr_bits = ^{if_addr, d_addr};

    assign w_accept  = (r_state == ST_IDLE) && (if_req || d_req);
    // Sole requester wins; on contention the port opposite the last grant wins.
    assign w_grant_d = d_req && (!if_req || !r_last_d);
    assign w_req_idx = w_grant_d ? d_addr[MEM_AW:1] : if_addr[MEM_AW:1];

    assign w_enter_done = SINGLE ? w_accept
                                 : ((r_state == ST_WAIT) && (r_cnt == 4'd1));
    assign w_acc_idx    = SINGLE ? w_req_idx             : r_idx;
    assign w_acc_wr     = SINGLE ? (w_grant_d && d_wr)   : r_wr;
    assign w_acc_sel_d  = SINGLE ? w_grant_d             : r_grant_d;
    assign w_acc_wdata  = SINGLE ? d_wdata               : r_wdata;

    // Array write port; blocked while reset is held so an aborted write is lost.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_done && w_acc_wr) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    // Sequencer: acceptance/arbitration, latency count, registered read data and valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_last_d   <= 1'b0;
            r_grant_d  <= 1'b0;
            r_wr       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 16'h0000;
            r_if_rdata <= 16'h0000;
            r_d_rdata  <= 16'h0000;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant_d <= w_grant_d;
                        r_last_d  <= w_grant_d;
                        r_idx     <= w_req_idx;
                        r_wr      <= w_grant_d && d_wr;
                        r_wdata   <= d_wdata;
                        r_cnt     <= CNT_LOAD;
                        r_state   <= SINGLE ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_enter_done) begin
                if (w_acc_sel_d) begin
                    r_d_valid <= 1'b1;
                    if (!w_acc_wr) begin
                        r_d_rdata <= r_mem[w_acc_idx];
                    end
                end else begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= r_mem[w_acc_idx];
                end
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign if_valid = r_if_valid;
    assign d_valid  = r_d_valid;
    assign busy     = (r_state != ST_IDLE);
    assign if_stall = if_req && !r_if_valid;
    assign d_stall  = d_req && !r_d_valid;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a cycle-by-cycle vector table for the LATENCY=4
// instance, plus hand sequences for reset, mid-write reset and LATENCY=1.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_wr;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] if_rdata, d_rdata;
    logic        if_valid, d_valid, if_stall, d_stall, busy;

    logic        u_if_req, u_d_req, u_d_wr;
    logic [15:0] u_if_addr, u_d_addr, u_d_wdata;
    logic [15:0] u_if_rdata, u_d_rdata;
    logic        u_if_valid, u_d_valid, u_if_stall, u_d_stall, u_busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_responder #(.MEM_AW(10), .LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .busy(busy)
    );

    mem_responder #(.MEM_AW(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(u_if_req), .if_addr(u_if_addr), .if_rdata(u_if_rdata),
        .if_valid(u_if_valid), .if_stall(u_if_stall),
        .d_req(u_d_req), .d_wr(u_d_wr), .d_addr(u_d_addr), .d_wdata(u_d_wdata),
        .d_rdata(u_d_rdata), .d_valid(u_d_valid), .d_stall(u_d_stall),
        .busy(u_busy)
    );

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dd;
        logic        iv;
        logic [15:0] ird;
        logic        dv;
        logic [15:0] drd;
        logic        bz;
        logic        ist;
        logic        dst;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ir, input logic [15:0] ia,
                       input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dd,
                       input logic iv, input logic [15:0] ird,
                       input logic dv, input logic [15:0] drd,
                       input logic bz, input logic ist, input logic dst);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.iv = iv; v.ird = ird; v.dv = dv; v.drd = drd;
        v.bz = bz; v.ist = ist; v.dst = dst;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // One data-port access on the LATENCY=4 instance, bounded wait for d_valid.
    task automatic d_access(input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, output logic [15:0] rdata);
        int n;
        @(posedge clk); #1;
        d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        #1;
        n = 0;
        while (d_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk($sformatf("d_access(%h).valid", addr), {15'd0, d_valid}, 16'h0001);
        chk($sformatf("d_access(%h).latency", addr), 16'(n), 16'd4);
        rdata = d_rdata;
        $display("access wr=%b addr=%h wdata=%h rdata=%h cycles=%0d", wr, addr, wdata, rdata, n);
        d_req = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        seen;

        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        u_if_req = 0; u_if_addr = 0; u_d_req = 0; u_d_wr = 0; u_d_addr = 0; u_d_wdata = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset.if_valid", {15'd0, if_valid}, 16'h0000);
        chk("reset.d_valid",  {15'd0, d_valid},  16'h0000);
        chk("reset.busy",     {15'd0, busy},     16'h0000);
        chk("reset.if_rdata", if_rdata, 16'h0000);
        chk("reset.d_rdata",  d_rdata,  16'h0000);
        chk("reset.if_stall", {15'd0, if_stall}, 16'h0000);
        chk("reset.d_stall",  {15'd0, d_stall},  16'h0000);

        // Preload word 5 for the fetch test
        d_access(1'b1, 16'h000A, 16'hA5A5, rd);

        // Write 1234 to 0x0010, then read back through 0x0011
        add(0,0, 1,1,16'h0010,16'h1234, 0,16'h0000, 0,16'h0000, 0,0,1);
        for (int i = 0; i < 3; i++)
            add(0,0, 1,1,16'h0010,16'h1234, 0,16'h0000, 0,16'h0000, 1,0,1);
        add(0,0, 1,1,16'h0010,16'h1234, 0,16'h0000, 1,16'h0000, 1,0,0);
        add(0,0, 1,0,16'h0011,16'hFFFF, 0,16'h0000, 0,16'h0000, 0,0,1);
        for (int i = 0; i < 3; i++)
            add(0,0, 1,0,16'h0011,16'hFFFF, 0,16'h0000, 0,16'h0000, 1,0,1);
        add(0,0, 1,0,16'h0011,16'hFFFF, 0,16'h0000, 1,16'h1234, 1,0,0);
        // Aliasing: write BEEF at 0x0002, read 0x0802
        add(0,0, 1,1,16'h0002,16'hBEEF, 0,16'h0000, 0,16'h1234, 0,0,1);
        for (int i = 0; i < 3; i++)
            add(0,0, 1,1,16'h0002,16'hBEEF, 0,16'h0000, 0,16'h1234, 1,0,1);
        add(0,0, 1,1,16'h0002,16'hBEEF, 0,16'h0000, 1,16'h1234, 1,0,0);
        add(0,0, 1,0,16'h0802,16'h0000, 0,16'h0000, 0,16'h1234, 0,0,1);
        for (int i = 0; i < 3; i++)
            add(0,0, 1,0,16'h0802,16'h0000, 0,16'h0000, 0,16'h1234, 1,0,1);
        add(0,0, 1,0,16'h0802,16'h0000, 0,16'h0000, 1,16'hBEEF, 1,0,0);
        // Single fetch of word 5
        add(1,16'h000A, 0,0,0,0, 0,16'h0000, 0,16'hBEEF, 0,1,0);
        for (int i = 0; i < 3; i++)
            add(1,16'h000A, 0,0,0,0, 0,16'h0000, 0,16'hBEEF, 1,1,0);
        add(1,16'h000A, 0,0,0,0, 1,16'hA5A5, 0,16'hBEEF, 1,0,0);
        add(0,0, 0,0,0,0, 0,16'hA5A5, 0,16'hBEEF, 0,0,0);
        // Contention, last grant is fetch: order D, I, D
        add(1,16'h0010, 1,0,16'h000A,0, 0,16'hA5A5, 0,16'hBEEF, 0,1,1);
        for (int i = 0; i < 3; i++)
            add(1,16'h0010, 1,0,16'h000A,0, 0,16'hA5A5, 0,16'hBEEF, 1,1,1);
        add(1,16'h0010, 1,0,16'h000A,0, 0,16'hA5A5, 1,16'hA5A5, 1,1,0);
        add(1,16'h0010, 1,0,16'h000A,0, 0,16'hA5A5, 0,16'hA5A5, 0,1,1);
        for (int i = 0; i < 3; i++)
            add(1,16'h0010, 1,0,16'h000A,0, 0,16'hA5A5, 0,16'hA5A5, 1,1,1);
        add(1,16'h0010, 1,0,16'h000A,0, 1,16'h1234, 0,16'hA5A5, 1,0,1);
        add(1,16'h0010, 1,0,16'h000A,0, 0,16'h1234, 0,16'hA5A5, 0,1,1);
        for (int i = 0; i < 3; i++)
            add(1,16'h0010, 1,0,16'h000A,0, 0,16'h1234, 0,16'hA5A5, 1,1,1);
        add(1,16'h0010, 1,0,16'h000A,0, 0,16'h1234, 1,16'hA5A5, 1,1,0);
        add(0,0, 0,0,0,0, 0,16'h1234, 0,16'hA5A5, 0,0,0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk); #1;
            if_req = vecs[k].ir; if_addr = vecs[k].ia;
            d_req = vecs[k].dr; d_wr = vecs[k].dw; d_addr = vecs[k].da; d_wdata = vecs[k].dd;
            #1;
            chk($sformatf("row%0d.if_valid", k), {15'd0, if_valid}, {15'd0, vecs[k].iv});
            chk($sformatf("row%0d.if_rdata", k), if_rdata, vecs[k].ird);
            chk($sformatf("row%0d.d_valid", k),  {15'd0, d_valid},  {15'd0, vecs[k].dv});
            chk($sformatf("row%0d.d_rdata", k),  d_rdata,  vecs[k].drd);
            chk($sformatf("row%0d.busy", k),     {15'd0, busy},     {15'd0, vecs[k].bz});
            chk($sformatf("row%0d.if_stall", k), {15'd0, if_stall}, {15'd0, vecs[k].ist});
            chk($sformatf("row%0d.d_stall", k),  {15'd0, d_stall},  {15'd0, vecs[k].dst});
            $display("row %0d: if_valid=%b if_rdata=%h d_valid=%b d_rdata=%h busy=%b",
                     k, if_valid, if_rdata, d_valid, d_rdata, busy);
        end

        // Reset in the middle of a write to 0x0020 (prior contents written as 0)
        d_access(1'b1, 16'h0020, 16'h0000, rd);
        @(posedge clk); #1;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h5555;
        @(posedge clk); #2;
        chk("midrst.c1_busy", {15'd0, busy}, 16'h0001);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0; d_wr = 1'b0;
        #1;
        chk("midrst.busy",     {15'd0, busy},    16'h0000);
        chk("midrst.d_valid",  {15'd0, d_valid}, 16'h0000);
        chk("midrst.if_rdata", if_rdata, 16'h0000);
        chk("midrst.d_rdata",  d_rdata,  16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            if (d_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst.no_d_valid", {15'd0, seen}, 16'h0000);
        d_access(1'b0, 16'h0020, 16'h0000, rd);
        chk("midrst.read_back", rd, 16'h0000);

        // LATENCY=1 instance: IDLE goes straight to DONE
        @(posedge clk); #1;
        u_d_req = 1'b1; u_d_wr = 1'b1; u_d_addr = 16'h0004; u_d_wdata = 16'h7777;
        #1;
        chk("lat1.w_c0_busy",  {15'd0, u_busy},    16'h0000);
        chk("lat1.w_c0_stall", {15'd0, u_d_stall}, 16'h0001);
        @(posedge clk); #2;
        chk("lat1.w_c1_valid", {15'd0, u_d_valid}, 16'h0001);
        chk("lat1.w_c1_busy",  {15'd0, u_busy},    16'h0001);
        chk("lat1.w_c1_rdata", u_d_rdata, 16'h0000);
        u_d_req = 1'b0; u_d_wr = 1'b0;
        @(posedge clk); #1;
        u_if_req = 1'b1; u_if_addr = 16'h0004;
        #1;
        chk("lat1.r_c0_busy",  {15'd0, u_busy},     16'h0000);
        chk("lat1.r_c0_stall", {15'd0, u_if_stall}, 16'h0001);
        chk("lat1.r_c0_valid", {15'd0, u_if_valid}, 16'h0000);
        @(posedge clk); #2;
        chk("lat1.r_c1_valid", {15'd0, u_if_valid}, 16'h0001);
        chk("lat1.r_c1_rdata", u_if_rdata, 16'h7777);
        chk("lat1.r_c1_stall", {15'd0, u_if_stall}, 16'h0000);
        u_if_req = 1'b0;
        @(posedge clk); #2;
        chk("lat1.c2_busy",  {15'd0, u_busy},     16'h0000);
        chk("lat1.c2_valid", {15'd0, u_if_valid}, 16'h0000);
        chk("lat1.c2_rdata", u_if_rdata, 16'h7777);
        $display("lat1 write/fetch 0x0004 -> if_rdata=%h", u_if_rdata);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
